// File: rtl/mini_src_mul_pkg.sv
// mini_src_mul_pkg: shared FSM states and Booth digit encodings for booth_mul_ctrl
package mini_src_mul_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [2:0] ZERO = 3'd0;
   localparam logic [2:0] POS1 = 3'd1;
   localparam logic [2:0] POS2 = 3'd2;
   localparam logic [2:0] NEG1 = 3'd3;
   localparam logic [2:0] NEG2 = 3'd4;
   function automatic logic [2:0] booth_digit(input logic [2:0] t);
      case (t)
         3'b001, 3'b010: return POS1;
         3'b011:         return POS2;
         3'b100:         return NEG2;
         3'b101, 3'b110: return NEG1;
         default:        return ZERO;
      endcase
   endfunction
endpackage

// File: rtl/booth_digit_sel.sv
// booth_digit_sel: radix-4 Booth triplet to addend (0, +-M, +-2M) at XW bits
//   triplet : {Q[1], Q[0], q_m1}
//   m_ext   : sign-extended multiplicand
//   addend  : digit * m_ext modulo 2^XW
module booth_digit_sel
   import mini_src_mul_pkg::*;
#(
   parameter int XW = 34
) (
   input  logic [2:0]    triplet,
   input  logic [XW-1:0] m_ext,
   output logic [XW-1:0] addend
);
   logic [2:0]    digit;
   logic [XW-1:0] mag;
   always_comb begin
      digit  = booth_digit(triplet);
      mag    = (digit == POS2 || digit == NEG2) ? m_ext << 1 : (digit == ZERO) ? '0 : m_ext;
      addend = (digit == NEG1 || digit == NEG2) ? ~mag + XW'(1) : mag;
   end
endmodule

// File: rtl/booth_mul_ctrl.sv
// booth_mul_ctrl: sequential radix-4 Booth signed multiplier, WIDTH/2 iterations
//   clk, rst_n               : clock, asynchronous active-low reset
//   start                    : begin a multiply (sampled in IDLE only)
//   multiplicand, multiplier : signed operands, captured on accept
//   busy                     : high while iterating
//   done                     : one-cycle pulse when prod_hi/prod_lo update
//   prod_hi, prod_lo         : upper/lower halves of the signed product
module booth_mul_ctrl
   import mini_src_mul_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = WIDTH / 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo
);
   localparam int XW = WIDTH + 2;
   localparam int CW = $clog2(ITER + 1);
   state_t          state, state_nx;
   logic [XW-1:0]   a, m_ext, addend, sum, a_sh;
   logic [WIDTH-1:0] q, q_sh;
   logic            q_m1, last;
   logic [CW-1:0]   cnt;
   booth_digit_sel #(.XW(XW)) u_sel (
      .triplet({q[1:0], q_m1}),
      .m_ext  (m_ext),
      .addend (addend)
   );
   // {A, Q, q_m1} arithmetic shift right by 2 after the add
   assign sum  = a + addend;
   assign a_sh = {{2{sum[XW-1]}}, sum[XW-1:2]};
   assign q_sh = {sum[1:0], q[WIDTH-1:2]};
   assign last = cnt == CW'(ITER - 1);
   always_comb begin
      state_nx = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
      busy     = state == RUN;
      done     = state == DONE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a       <= '0;
         m_ext   <= '0;
         q       <= '0;
         q_m1    <= 1'b0;
         cnt     <= '0;
         prod_hi <= '0;
         prod_lo <= '0;
      end else if (state == IDLE && start) begin
         a     <= '0;
         m_ext <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
         q     <= multiplier;
         q_m1  <= 1'b0;
         cnt   <= '0;
      end else if (state == RUN) begin
         a    <= a_sh;
         q    <= q_sh;
         q_m1 <= q[1];
         cnt  <= cnt + CW'(1);
         // the final shifted values go straight to the result registers
         if (last) begin
            prod_hi <= a_sh[WIDTH-1:0];
            prod_lo <= q_sh;
         end
      end
   end
endmodule
